operand_read_stage: RTL and testbench

Parametrised successor to the core's read pipeline stage, sitting between decode and execute. Accepts one decoded instruction per cycle over a valid/ready handshake, reads up to two source operands from the register file, and forwards same-cycle write-back data. Tracks pending destinations in a scoreboard so RAW/WAW hazards stall the instruction, and presents a registered operand bundle downstream. Adds backpressure, flush and a stall counter.

---
 rtl/operand_read_stage_pkg.sv | 41 ++++
 rtl/operand_read_stage_if.sv | 34 +++
 rtl/operand_read_stage_scoreboard.sv | 57 +++++
 rtl/operand_read_stage.sv | 90 +++++++++
 tb/tb_operand_read_stage.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/operand_read_stage_pkg.sv
// Shared decode helpers and operand bundle type for the operand read stage.
// Field positions follow the core's instruction format (rd/ra/rb at 25/20/15).
package operand_read_stage_pkg;
  localparam int ADDR_WIDTH = 30;
  localparam int INSN_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int NREGS      = 32;
  localparam int REG_W      = $clog2(NREGS);

  typedef logic [REG_W-1:0] RegId;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [INSN_WIDTH-1:0] insn;
    RegId                  rd;
    logic [DATA_WIDTH-1:0] opa;
    logic [DATA_WIDTH-1:0] opb;
    logic                  writes_rd;
  } OperandBundle;

  function automatic RegId get_rd(input logic [INSN_WIDTH-1:0] insn);
    return insn[21 +: REG_W];
  endfunction

  function automatic RegId get_ra(input logic [INSN_WIDTH-1:0] insn);
    return insn[16 +: REG_W];
  endfunction

  function automatic RegId get_rb(input logic [INSN_WIDTH-1:0] insn);
    return insn[11 +: REG_W];
  endfunction

  // r0 is hardwired zero; otherwise same-cycle write-back beats the register file.
  function automatic logic [DATA_WIDTH-1:0] bypass_sel(
    input RegId src, input logic [DATA_WIDTH-1:0] rf_data,
    input logic wb_valid, input RegId wb_reg, input logic [DATA_WIDTH-1:0] wb_data);
    if (src == '0) return '0;
    if (wb_valid && wb_reg == src) return wb_data;
    return rf_data;
  endfunction
endpackage

// File: rtl/operand_read_stage_if.sv
// Decode/regfile/write-back/execute bus seen by the operand read stage.
interface operand_read_stage_if;
  import operand_read_stage_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [INSN_WIDTH-1:0] in_insn;
  logic                  in_uses_ra;
  logic                  in_uses_rb;
  logic                  in_writes_rd;
  RegId                  rf_raddr_a;
  RegId                  rf_raddr_b;
  logic [DATA_WIDTH-1:0] rf_rdata_a;
  logic [DATA_WIDTH-1:0] rf_rdata_b;
  logic                  wb_valid;
  RegId                  wb_reg;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  out_valid;
  logic                  out_ready;
  OperandBundle          out_b;

  modport slave (
    input  in_valid, in_addr, in_insn, in_uses_ra, in_uses_rb, in_writes_rd,
    input  rf_rdata_a, rf_rdata_b, wb_valid, wb_reg, wb_data, out_ready,
    output in_ready, rf_raddr_a, rf_raddr_b, out_valid, out_b
  );

  modport master (
    output in_valid, in_addr, in_insn, in_uses_ra, in_uses_rb, in_writes_rd,
    output rf_rdata_a, rf_rdata_b, wb_valid, wb_reg, wb_data, out_ready,
    input  in_ready, rf_raddr_a, rf_raddr_b, out_valid, out_b
  );
endinterface

// File: rtl/operand_read_stage_scoreboard.sv
// Pending-destination scoreboard: busy bit per register, write-back aware lookups,
// sticky error on write-back to a register nobody was waiting for.
module operand_read_stage_scoreboard
  import operand_read_stage_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic flush_i,
  input  logic set_en_i,
  input  RegId set_reg_i,
  input  logic wb_valid_i,
  input  RegId wb_reg_i,
  input  RegId qa_i,
  input  RegId qb_i,
  input  RegId qd_i,
  output logic busy_a_o,
  output logic busy_b_o,
  output logic busy_d_o,
  output logic sb_err_o
);
  logic [NREGS-1:0] busy_q, busy_d;
  logic             sb_err_q, sb_err_d;
  logic             wb_live;

  // A register being written back this cycle no longer blocks a reader.
  assign busy_a_o = busy_q[qa_i] & ~(wb_valid_i & (wb_reg_i == qa_i));
  assign busy_b_o = busy_q[qb_i] & ~(wb_valid_i & (wb_reg_i == qb_i));
  assign busy_d_o = busy_q[qd_i] & ~(wb_valid_i & (wb_reg_i == qd_i));
  assign sb_err_o = sb_err_q;

  assign wb_live = wb_valid_i & (wb_reg_i != '0) & ~flush_i;

  always_comb begin
    busy_d   = busy_q;
    sb_err_d = sb_err_q;
    if (flush_i) begin
      busy_d = '0;
    end else begin
      if (wb_live) begin
        if (busy_q[wb_reg_i]) busy_d[wb_reg_i] = 1'b0;
        else                  sb_err_d         = 1'b1;
      end
      // Applied after the clear so a new producer of the same register wins.
      if (set_en_i) busy_d[set_reg_i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= '0;
      sb_err_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      sb_err_q <= sb_err_d;
    end
  end
endmodule

// File: rtl/operand_read_stage.sv
// Operand read stage: regfile read with write-back bypass, scoreboard hazard
// stall, registered operand bundle toward execute, saturating stall counter.
module operand_read_stage
  import operand_read_stage_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  operand_read_stage_if.slave  bus,
  output logic [CNT_WIDTH-1:0] stall_cnt_o,
  output logic                 sb_err_o
);
  RegId                  ra, rb, rd;
  logic [DATA_WIDTH-1:0] opa, opb;
  logic                  busy_a, busy_b, busy_d;
  logic                  hazard, fire, set_en;
  logic                  out_valid_q, out_valid_d;
  OperandBundle          out_q, out_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  assign ra = get_ra(bus.in_insn);
  assign rb = get_rb(bus.in_insn);
  assign rd = get_rd(bus.in_insn);
  assign bus.rf_raddr_a = ra;
  assign bus.rf_raddr_b = rb;

  assign opa = bus.in_uses_ra ? bypass_sel(ra, bus.rf_rdata_a, bus.wb_valid, bus.wb_reg, bus.wb_data) : '0;
  assign opb = bus.in_uses_rb ? bypass_sel(rb, bus.rf_rdata_b, bus.wb_valid, bus.wb_reg, bus.wb_data) : '0;

  assign hazard = bus.in_valid & ((bus.in_uses_ra & busy_a) | (bus.in_uses_rb & busy_b) |
                                  (bus.in_writes_rd & busy_d));
  assign bus.in_ready = rst_n & ~hazard & (~out_valid_q | bus.out_ready) & ~flush_i;
  assign fire   = bus.in_valid & bus.in_ready;
  assign set_en = fire & bus.in_writes_rd & (rd != '0);

  operand_read_stage_scoreboard u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush_i),
    .set_en_i   (set_en),
    .set_reg_i  (rd),
    .wb_valid_i (bus.wb_valid),
    .wb_reg_i   (bus.wb_reg),
    .qa_i       (ra),
    .qb_i       (rb),
    .qd_i       (rd),
    .busy_a_o   (busy_a),
    .busy_b_o   (busy_b),
    .busy_d_o   (busy_d),
    .sb_err_o   (sb_err_o)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    cnt_d       = cnt_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (fire) begin
      out_valid_d     = 1'b1;
      out_d.addr      = bus.in_addr;
      out_d.insn      = bus.in_insn;
      out_d.rd        = rd;
      out_d.opa       = opa;
      out_d.opb       = opb;
      out_d.writes_rd = bus.in_writes_rd;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    if (hazard & ~flush_i & ~&cnt_q) cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_b     = out_q;
  assign stall_cnt_o   = cnt_q;
endmodule

// File: tb/tb_operand_read_stage.sv
// Directed bench for operand_read_stage: array/queue-free behavioural model checked
// every cycle at the falling edge, plus hand-computed literal expectations.
module tb_operand_read_stage;
  import operand_read_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] stall_cnt;
  logic        sb_err;

  operand_read_stage_if bus ();

  operand_read_stage #(.CNT_WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush),
    .bus         (bus),
    .stall_cnt_o (stall_cnt),
    .sb_err_o    (sb_err)
  );

  always #5 clk = ~clk;

  logic [DATA_WIDTH-1:0] rf [NREGS];
  assign bus.rf_rdata_a = rf[bus.rf_raddr_a];
  assign bus.rf_rdata_b = rf[bus.rf_raddr_b];

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
  endtask

  // ---- behavioural model ----
  logic [NREGS-1:0]      m_busy = '0;
  bit                    m_vld = 0;
  bit                    m_err = 0;
  logic [15:0]           m_cnt = '0;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [INSN_WIDTH-1:0] m_insn;
  int                    m_rd;
  logic [DATA_WIDTH-1:0] m_opa, m_opb;
  bit                    m_wr;

  function automatic bit pending(input int r);
    return r != 0 && m_busy[r] && !(bus.wb_valid && int'(bus.wb_reg) == r);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] operand(input int r);
    if (r == 0) return '0;
    if (bus.wb_valid && int'(bus.wb_reg) == r) return bus.wb_data;
    return rf[r];
  endfunction

  always @(negedge clk) begin : model
    int  ra_, rb_, rd_;
    bit  hz, rdy;
    if (!rst_n) begin
      m_busy = '0; m_vld = 0; m_err = 0; m_cnt = '0;
    end
    rd_ = int'(bus.in_insn[25:21]);
    ra_ = int'(bus.in_insn[20:16]);
    rb_ = int'(bus.in_insn[15:11]);
    hz  = bus.in_valid && ((bus.in_uses_ra && pending(ra_)) || (bus.in_uses_rb && pending(rb_)) ||
                           (bus.in_writes_rd && pending(rd_)));
    rdy = rst_n && !hz && (!m_vld || bus.out_ready) && !flush;
    chk("in_ready", 64'(bus.in_ready), 64'(rdy));
    chk("out_valid", 64'(bus.out_valid), 64'(m_vld));
    if (m_vld) begin
      chk("out_addr", 64'(bus.out_b.addr), 64'(m_addr));
      chk("out_insn", 64'(bus.out_b.insn), 64'(m_insn));
      chk("out_rd", 64'(bus.out_b.rd), 64'(m_rd));
      chk("out_opa", 64'(bus.out_b.opa), 64'(m_opa));
      chk("out_opb", 64'(bus.out_b.opb), 64'(m_opb));
      chk("out_writes_rd", 64'(bus.out_b.writes_rd), 64'(m_wr));
    end
    chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
    chk("sb_err", 64'(sb_err), 64'(m_err));
    chk("busy", 64'(dut.u_sb.busy_q), 64'(m_busy));
    if (rst_n) begin
      if (flush) begin
        m_vld = 0; m_busy = '0;
      end else begin
        if (hz && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (bus.wb_valid && bus.wb_reg != '0) begin
          if (m_busy[bus.wb_reg]) m_busy[bus.wb_reg] = 1'b0;
          else m_err = 1;
        end
        if (bus.in_valid && rdy) begin
          m_vld  = 1;
          m_addr = bus.in_addr;
          m_insn = bus.in_insn;
          m_rd   = rd_;
          m_opa  = bus.in_uses_ra ? operand(ra_) : '0;
          m_opb  = bus.in_uses_rb ? operand(rb_) : '0;
          m_wr   = bus.in_writes_rd;
          if (bus.in_writes_rd && rd_ != 0) m_busy[rd_] = 1'b1;
          $display("READ: addr=%h op=%h", {bus.in_addr, 2'b00}, bus.in_insn[31:26]);
        end else if (bus.out_ready) begin
          m_vld = 0;
        end
      end
    end
  end

  // ---- stimulus ----
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic peek();
    @(negedge clk);
    #1;
  endtask

  task automatic drv(input bit v, input logic [4:0] rd, input logic [4:0] ra, input logic [4:0] rb,
                     input bit ua, input bit ub, input bit wr, input logic [ADDR_WIDTH-1:0] addr);
    bus.in_valid     = v;
    bus.in_insn      = {6'h11, rd, ra, rb, 11'h0};
    bus.in_uses_ra   = ua;
    bus.in_uses_rb   = ub;
    bus.in_writes_rd = wr;
    bus.in_addr      = addr;
  endtask

  task automatic wb(input bit v, input logic [4:0] r, input logic [DATA_WIDTH-1:0] d);
    bus.wb_valid = v;
    bus.wb_reg   = r;
    bus.wb_data  = d;
  endtask

  task automatic idle();
    drv(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, '0);
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) rf[i] = 32'h100 + i;
    rf[3] = 32'h11;
    rf[4] = 32'h22;
    idle();
    wb(0, 5'd0, '0);
    bus.out_ready = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'h0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
    chk("rst_opa", 64'(bus.out_b.opa), 64'h0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // basic read ra=3, rb=4
    drv(1, 5'd0, 5'd3, 5'd4, 1, 1, 0, 30'h10);
    step();
    idle();
    peek();
    chk("basic_valid", 64'(bus.out_valid), 64'h1);
    chk("basic_opa", 64'(bus.out_b.opa), 64'h11);
    chk("basic_opb", 64'(bus.out_b.opb), 64'h22);
    step();

    // RAW: writer rd=5, then reader ra=5 stalls until write-back bypass
    drv(1, 5'd5, 5'd1, 5'd2, 1, 1, 1, 30'h11);
    step();
    drv(1, 5'd6, 5'd5, 5'd0, 1, 0, 1, 30'h12);
    step(3);
    wb(1, 5'd5, 32'hAB);
    peek();
    chk("raw_stall_cnt", 64'(stall_cnt), 64'd3);
    chk("raw_wb_ready", 64'(bus.in_ready), 64'h1);
    step();
    idle();
    wb(0, 5'd0, '0);
    peek();
    chk("raw_opa_bypass", 64'(bus.out_b.opa), 64'hAB);
    chk("raw_busy5", 64'(dut.u_sb.busy_q[5]), 64'h0);
    step();

    // backpressure: out_ready low holds bundle and blocks input
    bus.out_ready = 1'b0;
    drv(1, 5'd0, 5'd8, 5'd9, 1, 1, 0, 30'h20);
    step();
    drv(1, 5'd0, 5'd10, 5'd0, 1, 0, 0, 30'h21);
    step(3);
    peek();
    chk("bp_in_ready", 64'(bus.in_ready), 64'h0);
    chk("bp_hold_addr", 64'(bus.out_b.addr), 64'h20);
    chk("bp_hold_opb", 64'(bus.out_b.opb), 64'h109);
    step();
    bus.out_ready = 1'b1;
    peek();
    chk("bp_release_ready", 64'(bus.in_ready), 64'h1);
    step();
    idle();
    peek();
    chk("bp_next_addr", 64'(bus.out_b.addr), 64'h21);
    chk("bp_next_opa", 64'(bus.out_b.opa), 64'h10A);
    step();

    // WAW: rd=7 busy, write-back of r7 in the same cycle lets the new writer go
    drv(1, 5'd7, 5'd0, 5'd0, 0, 0, 1, 30'h30);
    step();
    drv(1, 5'd7, 5'd0, 5'd0, 0, 0, 1, 30'h31);
    wb(1, 5'd7, 32'h77);
    peek();
    chk("waw_ready", 64'(bus.in_ready), 64'h1);
    step();
    idle();
    wb(0, 5'd0, '0);
    peek();
    chk("waw_busy7", 64'(dut.u_sb.busy_q[7]), 64'h1);
    chk("waw_valid", 64'(bus.out_valid), 64'h1);
    step();

    // flush during a stall with r5 and r7 pending
    drv(1, 5'd5, 5'd0, 5'd0, 0, 0, 1, 30'h40);
    step();
    drv(1, 5'd0, 5'd5, 5'd7, 1, 1, 0, 30'h41);
    step(2);
    flush = 1'b1;
    peek();
    chk("flush_ready", 64'(bus.in_ready), 64'h0);
    step();
    flush = 1'b0;
    peek();
    chk("flush_valid", 64'(bus.out_valid), 64'h0);
    chk("flush_busy", 64'(dut.u_sb.busy_q), 64'h0);
    chk("flush_next_ready", 64'(bus.in_ready), 64'h1);
    step();
    idle();
    wb(1, 5'd9, 32'h55);
    peek();
    chk("flush_fire_opa", 64'(bus.out_b.opa), 64'h105);
    chk("flush_fire_opb", 64'(bus.out_b.opb), 64'h107);
    step();
    wb(0, 5'd0, '0);
    peek();
    chk("sb_err_set", 64'(sb_err), 64'h1);
    step();

    // r0 writer/reader pair: no dependency, r0 reads as zero
    drv(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 30'h50);
    step();
    drv(1, 5'd0, 5'd0, 5'd1, 1, 1, 0, 30'h51);
    peek();
    chk("r0_ready", 64'(bus.in_ready), 64'h1);
    step();
    idle();
    peek();
    chk("r0_opa", 64'(bus.out_b.opa), 64'h0);
    chk("r0_opb", 64'(bus.out_b.opb), 64'h101);
    chk("r0_busy", 64'(dut.u_sb.busy_q), 64'h0);
    step();

    // asynchronous reset in the middle of a stall
    drv(1, 5'd5, 5'd0, 5'd0, 0, 0, 1, 30'h60);
    step();
    drv(1, 5'd0, 5'd5, 5'd0, 1, 0, 0, 30'h61);
    step(2);
    rst_n = 1'b0;
    peek();
    chk("mid_rst_valid", 64'(bus.out_valid), 64'h0);
    chk("mid_rst_ready", 64'(bus.in_ready), 64'h0);
    chk("mid_rst_cnt", 64'(stall_cnt), 64'h0);
    chk("mid_rst_err", 64'(sb_err), 64'h0);
    step();
    idle();
    rst_n = 1'b1;
    step(2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
